// File: rtl/video_mem_arbiter.sv
// Shares one single-port video memory between the display fetch path and the CPU register port.
// Optional build macro STARVE_GUARD_EN adds a wait counter that forces a CPU slot after MAX_WAIT denied cycles.
module video_mem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              display_on,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_grant,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              underrun,
  input  logic              clr_underrun,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {C_IDLE, C_WAIT, C_ISSUE, C_RESP} cpu_state_t;
  typedef enum logic [1:0] {T_NONE, T_DISP, T_CPU_RD, T_CPU_WR} tag_t;

  if (MAX_WAIT < 1) begin : g_max_wait_check
    $error("MAX_WAIT must be at least 1");
  end

  cpu_state_t            state, state_d;
  tag_t                  tag_issue, tag_resp;
  logic                  cpu_elig, cpu_win, disp_win, force_cpu;
  logic [DATA_W-1:0]     cpu_rdata_q;

`ifdef STARVE_GUARD_EN
  localparam int WAIT_W = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
  logic [WAIT_W-1:0] wait_cnt;

  assign force_cpu = (state == C_WAIT) && (wait_cnt == WAIT_W'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (cpu_win) begin
      wait_cnt <= '0;
    end else if (state == C_WAIT && wait_cnt != WAIT_W'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end
`else
  assign force_cpu = 1'b0;
`endif

  // Grants are masked during reset so a held request cannot leak through the combinational path.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state;
    cpu_elig = cpu_req && (state == C_IDLE || state == C_WAIT);
    cpu_win  = !reset && cpu_elig && (!disp_req || !display_on || force_cpu);
    disp_win = !reset && disp_req && !cpu_win;
    unique case (state)
      C_IDLE:  if (cpu_win) state_d = C_ISSUE;
               else if (cpu_req) state_d = C_WAIT;
      C_WAIT:  if (cpu_win) state_d = C_ISSUE;
               else if (!cpu_req) state_d = C_IDLE;
      C_ISSUE: state_d = C_RESP;
      C_RESP:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= C_IDLE;
      tag_issue   <= T_NONE;
      tag_resp    <= T_NONE;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      underrun    <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state    <= state_d;
      tag_resp <= tag_issue;
      mem_en   <= disp_win || cpu_win;
      mem_we   <= cpu_win && cpu_we;
      if (disp_win) begin
        mem_addr  <= disp_addr;
        tag_issue <= T_DISP;
      end else if (cpu_win) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
        tag_issue <= cpu_we ? T_CPU_WR : T_CPU_RD;
      end else begin
        tag_issue <= T_NONE;
      end
      // A refusal in the same cycle as a clear must leave the flag set.
      if (disp_req && !disp_win) underrun <= 1'b1;
      else if (clr_underrun)     underrun <= 1'b0;
      cpu_rdata_q <= cpu_rdata;
    end
  end

  assign disp_grant  = disp_win;
  assign disp_rvalid = (tag_resp == T_DISP);
  assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
  assign cpu_ready   = (state == C_RESP);
  assign cpu_rdata   = (tag_resp == T_CPU_RD) ? mem_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Directed bench for video_mem_arbiter with a behavioural 1-cycle-latency memory.
// Starvation expectations follow STARVE_GUARD_EN (MAX_WAIT=4 here).
module tb_video_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
`ifdef STARVE_GUARD_EN
  localparam int GRANT_T = 5;
`else
  localparam int GRANT_T = 10;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              display_on;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_grant;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_rdata;
  logic              underrun;
  logic              clr_underrun;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  video_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset), .display_on(display_on),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_grant(disp_grant),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .underrun(underrun), .clr_underrun(clr_underrun),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Video memory macro model; seeded on the first edge.
  logic [DATA_W-1:0] mem_model [0:(1<<ADDR_W)-1];
  bit seeded = 1'b0;
  always @(posedge clk) begin
    if (!seeded) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem_model[i] = '0;
      mem_model[16] = 8'hA0;
      mem_model[17] = 8'hA1;
      mem_model[18] = 8'hA2;
      mem_model[19] = 8'hA3;
      seeded = 1'b1;
    end
    if (mem_en) begin
      if (mem_we) mem_model[mem_addr] = mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; display_on = 1'b1; disp_req = 1'b1; disp_addr = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; clr_underrun = 1'b0;

    // Reset held three cycles with both requesters active
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      check("rst_outputs", {disp_grant, disp_rvalid, disp_rdata, cpu_ready, cpu_rdata,
                            underrun, mem_en, mem_we, mem_addr, mem_wdata}, 64'd0);
    end
    reset = 1'b0; disp_req = 1'b0; cpu_req = 1'b0;

    // Display stream 0x010-0x013 in the active area
    for (int i = 0; i < 7; i++) begin
      tick();
      display_on = 1'b1; disp_req = (i < 4); disp_addr = ADDR_W'(16 + i);
      #1;
      check("ds_grant", disp_grant, i < 4);
      check("ds_mem_en", mem_en, (i >= 1 && i < 5));
      if (i >= 1 && i < 5) check("ds_mem_addr", mem_addr, 16 + i - 1);
      check("ds_rvalid", disp_rvalid, (i >= 2 && i < 6));
      if (i >= 2 && i < 6) check("ds_rdata", disp_rdata, 8'hA0 + i - 2);
    end
    check("ds_underrun", underrun, 0);

    // CPU write 0x55 to 0x3FF in blanking; inputs change after grant
    tick(); display_on = 1'b0; disp_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 8'h55; #1;
    check("wr_ready_n", cpu_ready, 0);
    tick(); cpu_wdata = 8'hEE; cpu_addr = 10'h000; #1;
    check("wr_mem", {mem_en, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 10'h3FF, 8'h55});
    check("wr_ready_n1", cpu_ready, 0);
    tick(); #1;
    check("wr_ready", cpu_ready, 1);
    tick(); cpu_req = 1'b0; #1;
    check("wr_after", {cpu_ready, mem_en}, 0);

    // CPU read back 0x3FF
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF; #1;
    tick(); #1;
    check("rd_mem", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'h3FF});
    tick(); #1;
    check("rd_ready", cpu_ready, 1);
    check("rd_data", cpu_rdata, 8'h55);
    tick(); cpu_req = 1'b0; cpu_addr = '0; #1;
    check("rd_ready_off", cpu_ready, 0);
    check("rd_hold", cpu_rdata, 8'h55);

    // Blanking contention with a simultaneous clear: CPU wins, set beats clear
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    disp_req = 1'b1; disp_addr = 10'h020; clr_underrun = 1'b1; #1;
    check("bc_grant", disp_grant, 0);
    check("bc_underrun_pre", underrun, 0);
    tick(); disp_req = 1'b0; clr_underrun = 1'b0; #1;
    check("bc_underrun", underrun, 1);
    check("bc_mem", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'h010});
    tick(); #1;
    check("bc_ready", cpu_ready, 1);
    check("bc_rdata", cpu_rdata, 8'hA0);
    tick(); cpu_req = 1'b0; clr_underrun = 1'b1; #1;
    check("bc_sticky", underrun, 1);
    tick(); clr_underrun = 1'b0; #1;
    check("bc_cleared", underrun, 0);

    // Lone display request in blanking is granted
    tick(); disp_req = 1'b1; disp_addr = 10'h011; #1;
    check("lone_disp_grant", disp_grant, 1);
    tick(); disp_req = 1'b0; #1;
    tick(); #1;
    check("lone_disp_rvalid", {disp_rvalid, disp_rdata}, {1'b1, 8'hA1});
    check("lone_disp_underrun", underrun, 0);

    // Lone CPU request in the active area is granted
    tick(); display_on = 1'b1; cpu_req = 1'b1; cpu_we = 1'b1;
    cpu_addr = 10'h100; cpu_wdata = 8'h3C; #1;
    tick(); #1;
    check("lone_cpu_mem", {mem_en, mem_we, mem_addr}, {1'b1, 1'b1, 10'h100});
    tick(); #1;
    check("lone_cpu_ready", cpu_ready, 1);
    tick(); cpu_req = 1'b0; #1;

    // Starvation: continuous display fetch, CPU read held
    for (int t = 0; t <= GRANT_T + 3; t++) begin
      tick();
      display_on = (t < 10); disp_req = 1'b1; disp_addr = 10'h011;
      cpu_req = (t <= GRANT_T + 2); cpu_we = 1'b0; cpu_addr = 10'h012;
      #1;
      check("sv_disp_grant", disp_grant, t != GRANT_T);
      check("sv_cpu_ready", cpu_ready, t == GRANT_T + 2);
      if (t == GRANT_T + 2) check("sv_cpu_rdata", cpu_rdata, 8'hA2);
      check("sv_underrun", underrun, t > GRANT_T);
    end
    tick(); disp_req = 1'b0; cpu_req = 1'b0; clr_underrun = 1'b1; #1;
    tick(); clr_underrun = 1'b0; #1;

    // Reset the cycle after a CPU grant drops the access; held request restarts
    tick(); display_on = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h013; #1;
    tick(); reset = 1'b1; #1;
    check("mr_issued", mem_en, 1);
    tick(); reset = 1'b0; #1;
    check("mr_dropped", {cpu_ready, disp_rvalid, mem_en, cpu_rdata}, 0);
    tick(); #1;
    check("mr_reissue", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 10'h013});
    tick(); #1;
    check("mr_ready", cpu_ready, 1);
    check("mr_rdata", cpu_rdata, 8'hA3);
    tick(); cpu_req = 1'b0; #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
